// File: rtl/reciprocal_seq.sv
// reciprocal_seq: sequential fixed-point reciprocal, out = 2^(2F) / in.
// Radix-2 restoring division that produces one quotient bit per clock and
// uses a start/done handshake. The result saturates to all ones, and a zero
// divisor is flagged.
//
// Optional feature macro: RECIPROCAL_ROUND_EN
//   undefined : truncating result with N = 2F+1 iterations.
//   defined   : one extra guard iteration (N = 2F+2), round-half-up.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request; only sampled while busy = 0
//   in           unsigned operand, value in * 2^-F, captured on accept
//   busy         iteration in progress (accept edge through result edge)
//   done         one-cycle pulse; out and flags valid
//   out          reciprocal result, held until the next accepted start
//   saturated    true quotient exceeded all ones; out clamped
//   div_by_zero  in was zero; out = all ones
module reciprocal_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int FRACTION_BITS = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  saturated,
    output logic                  div_by_zero
);

    localparam int W = DATA_WIDTH;
`ifdef RECIPROCAL_ROUND_EN
    localparam int N = 2*FRACTION_BITS + 2;
`else
    localparam int N = 2*FRACTION_BITS + 1;
`endif
    localparam int CW = $clog2(N + 1);
    // The result path is wide enough to hold the full quotient plus a
    // rounding carry, so the saturation test is a simple OR of the high bits.
    localparam int QX = N + W + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state, nxt;
    logic [W-1:0]    divisor;
    // The remainder is always below the divisor, so W bits hold it.
    // Each trial value is W+1 bits wide.
    logic [W-1:0]    rem;
    logic [N-1:0]    quo;
    logic [CW-1:0]   cnt;
    logic            zero_pend;

    logic            dbit;
    logic [W:0]      trial;
    logic            ge;
    logic [QX-1:0]   qext;
    logic [QX-1:0]   res;
    logic            sat_c;

    // The dividend is 2^(2F) (or 2^(2F+1) with rounding). Its only set bit
    // is the first one shifted in, which is the step that has the counter
    // still at its load value.
    assign dbit  = (cnt == CW'(N - 1));
    assign trial = {rem, dbit};
    assign ge    = (trial >= {1'b0, divisor});

    always_comb begin
        qext = QX'(quo);
`ifdef RECIPROCAL_ROUND_EN
        // quo[0] is the guard bit. A carry out of all ones lands in bit W,
        // and the saturation test catches it.
        res  = (qext >> 1) + QX'(quo[0]);
`else
        res  = qext;
`endif
        sat_c = |(res >> W);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = CALC;
            // A zero divisor spends one pass-through cycle here and does
            // no iteration, which puts its result on edge E+2.
            CALC: if (zero_pend || cnt == '0) nxt = FIN;
            FIN:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            zero_pend   <= 1'b0;
            done        <= 1'b0;
            out         <= '0;
            saturated   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        divisor   <= in;
                        rem       <= '0;
                        quo       <= '0;
                        cnt       <= CW'(N - 1);
                        zero_pend <= (in == '0);
                    end
                end
                CALC: begin
                    if (!zero_pend) begin
                        if (ge) begin
                            rem <= W'(trial - {1'b0, divisor});
                        end else begin
                            rem <= trial[W-1:0];
                        end
                        quo <= {quo[N-2:0], ge};
                        cnt <= cnt - CW'(1);
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    if (zero_pend) begin
                        out         <= '1;
                        saturated   <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        out         <= sat_c ? '1 : res[W-1:0];
                        saturated   <= sat_c;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reciprocal_seq.sv
// Directed bench for reciprocal_seq at the default parameters (W=32, F=30).
// It uses a vector table of operands with hand-computed reciprocals and
// latencies. Hand-written sequences then cover a start while busy, a reset
// in mid-operation, and recovery after that reset.
module tb_reciprocal_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] din;
    logic        busy, done, saturated, div_by_zero;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

`ifdef RECIPROCAL_ROUND_EN
    localparam int          LAT   = 63;
    localparam logic [31:0] R1P5  = 32'h2AAAAAAB;
`else
    localparam int          LAT   = 62;
    localparam logic [31:0] R1P5  = 32'h2AAAAAAA;
`endif

    reciprocal_seq #(.DATA_WIDTH(32), .FRACTION_BITS(30)) dut (
        .clk(clk), .rst(rst), .start(start), .in(din),
        .busy(busy), .done(done), .out(out),
        .saturated(saturated), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
        logic        sat;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise start for one edge, scramble din afterwards, and count the edges
    // from the accepting edge until done is seen. The wait is bounded at 200.
    task automatic do_op(input logic [31:0] v, output int lat);
        start = 1'b1;
        din   = v;
        @(posedge clk); #1;
        start = 1'b0;
        din   = $urandom;
        check("busy_at_accept", 64'(busy), 64'd1);
        check("no_done_at_accept", 64'(done), 64'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 200);
        check("busy_low_at_done", 64'(busy), 64'd0);
    endtask

    vec_t vec[9];
    int   lat;
    int   ndone;
    int   dlat;

    initial begin
        vec[0] = '{32'h40000000, 32'h40000000, 1'b0, 1'b0, LAT};  // 1.0
        vec[1] = '{32'h80000000, 32'h20000000, 1'b0, 1'b0, LAT};  // 2.0
        vec[2] = '{32'h60000000, R1P5,         1'b0, 1'b0, LAT};  // 1.5
        vec[3] = '{32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, LAT};  // tiny
        vec[4] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 2};    // zero
        vec[5] = '{32'h10000000, 32'hFFFFFFFF, 1'b1, 1'b0, LAT};  // exactly 2^32
        vec[6] = '{32'h10000001, 32'hFFFFFFF0, 1'b0, 1'b0, LAT};  // just fits
        vec[7] = '{32'hFFFFFFFF, 32'h10000000, 1'b0, 1'b0, LAT};  // max operand
        vec[8] = '{32'h20000000, 32'h80000000, 1'b0, 1'b0, LAT};  // 0.5

        rst = 1'b1; start = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 64'(out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sat", 64'(saturated), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Each operation starts in the done cycle of the one before it,
        // which exercises back-to-back acceptance.
        for (int i = 0; i < 9; i++) begin
            do_op(vec[i].din, lat);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vec[i].lat));
            check($sformatf("v%0d_out", i), 64'(out), 64'(vec[i].exp));
            check($sformatf("v%0d_sat", i), 64'(saturated), 64'(vec[i].sat));
            check($sformatf("v%0d_dz", i), 64'(div_by_zero), 64'(vec[i].dz));
        end
        @(posedge clk); #1;
        check("done_single_pulse", 64'(done), 64'd0);
        check("out_held", 64'(out), 64'h80000000);

        // A second start at E+10 is ignored: one done, with the 1.0 result.
        start = 1'b1; din = 32'h40000000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; din = 32'h80000000;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; dlat = 0;
        for (int k = 11; k <= 90; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                dlat = k;
            end
        end
        check("ign_done_count", 64'(ndone), 64'd1);
        check("ign_lat", 64'(dlat), 64'(LAT));
        check("ign_out", 64'(out), 64'h40000000);

        // A divide by zero first leaves out and div_by_zero set. A reset at
        // E+20 of the next op must then clear everything and produce no done.
        do_op(32'h0, lat);
        check("dz_before_rst", 64'(div_by_zero), 64'd1);
        start = 1'b1; din = 32'h40000000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_out", 64'(out), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_sat", 64'(saturated), 64'd0);
        check("mrst_dz", 64'(div_by_zero), 64'd0);
        ndone = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mrst_no_done", 64'(ndone), 64'd0);
        do_op(32'h40000000, lat);
        check("post_rst_lat", 64'(lat), 64'(LAT));
        check("post_rst_out", 64'(out), 64'h40000000);
        check("post_rst_sat", 64'(saturated), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
